// File: rtl/lcd_timing_gen.sv
// Raster timing generator for an RGB LCD panel: DE/HSYNC/VSYNC, pixel coordinates
// and line/frame strobes, all registered one clock behind the h/v counters.
module lcd_timing_gen #(
   parameter int   H_ACTIVE = 800,
   parameter int   H_FP     = 40,
   parameter int   H_SYNC   = 128,
   parameter int   H_BP     = 88,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 13,
   parameter int   V_SYNC   = 3,
   parameter int   V_BP     = 29,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   XW       = 11,
   parameter int   YW       = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          lcd_de,
   output logic          lcd_hsync,
   output logic          lcd_vsync,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEGIN  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEGIN  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] r_h_cnt;
   logic [VW-1:0] r_v_cnt;

   logic w_h_last;
   logic w_v_last;
   logic w_de;
   logic w_hs_act;
   logic w_vs_act;
   logic w_h_zero;

   assign w_h_last = (r_h_cnt == H_LAST);
   assign w_v_last = (r_v_cnt == V_LAST);
   assign w_h_zero = (r_h_cnt == '0);
   assign w_de     = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
   assign w_hs_act = (r_h_cnt >= HS_BEGIN) && (r_h_cnt < HS_END);
   // vsync depends on v_cnt only, so its edges land on h_cnt = 0
   assign w_vs_act = (r_v_cnt >= VS_BEGIN) && (r_v_cnt < VS_END);

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         r_h_cnt     <= '0;
         r_v_cnt     <= '0;
         lcd_de      <= 1'b0;
         lcd_hsync   <= ~HS_POL;
         lcd_vsync   <= ~VS_POL;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
         end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
         end
         lcd_de      <= w_de;
         lcd_hsync   <= w_hs_act ? HS_POL : ~HS_POL;
         lcd_vsync   <= w_vs_act ? VS_POL : ~VS_POL;
         x           <= w_de ? XW'(r_h_cnt) : '0;
         y           <= w_de ? YW'(r_v_cnt) : '0;
         line_start  <= w_de && w_h_zero;
         frame_start <= w_h_zero && (r_v_cnt == '0);
      end
   end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a small 8x6 raster (H 4/1/2/1, V 3/1/1/1).
// Output index p counts decoded pixels from the first (0,0) after reset/enable.
module tb_lcd_timing_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic       lcd_de;
   logic       lcd_hsync;
   logic       lcd_vsync;
   logic [2:0] x;
   logic [1:0] y;
   logic       line_start;
   logic       frame_start;

   int n_cmp  = 0;
   int n_fail = 0;

   // bundle order: de, hsync, vsync, x[2:0], y[1:0], line_start, frame_start
   logic [9:0] got;
   localparam logic [9:0] IDLE = 10'b0_1_1_000_00_0_0;

   assign got = {lcd_de, lcd_hsync, lcd_vsync, x, y, line_start, frame_start};

   lcd_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .XW(3), .YW(2)
   ) dut (
      .clk(clk), .rst(rst), .en(en),
      .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
      .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs for decoded pixel index p on the 8-clk line, 6-line frame
   function automatic logic [9:0] exp_at(input int p);
      int h, v;
      logic de, hs, vs, ls, fs;
      logic [2:0] ex;
      logic [1:0] ey;
      h  = p % 8;
      v  = (p / 8) % 6;
      de = (h < 4) && (v < 3);
      hs = !(h == 5 || h == 6);
      vs = (v != 4);
      ex = de ? 3'(h) : 3'd0;
      ey = de ? 2'(v) : 2'd0;
      ls = de && (h == 0);
      fs = (h == 0) && (v == 0);
      return {de, hs, vs, ex, ey, ls, fs};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (got !== IDLE) begin
            n_fail++;
            $display("FAIL reset_hold clk%0d: got %b want %b", i, got, IDLE);
         end
      end
   endtask

   task automatic test_first_frame();
      rst = 1'b0;
      for (int p = 0; p < 8; p++) begin
         tick();
         n_cmp++;
         if (got !== exp_at(p)) begin
            n_fail++;
            $display("FAIL first_frame p%0d: got %b want %b", p, got, exp_at(p));
         end
      end
   endtask

   task automatic test_hsync();
      int hs_low = 0;
      for (int p = 8; p < 48; p++) begin
         tick();
         if (!lcd_hsync) hs_low++;
         n_cmp++;
         if (got !== exp_at(p)) begin
            n_fail++;
            $display("FAIL hsync p%0d: got %b want %b", p, got, exp_at(p));
         end
      end
      n_cmp++;
      if (hs_low !== 10) begin
         n_fail++;
         $display("FAIL hsync_low_count: got %0d want 10", hs_low);
      end
   endtask

   task automatic test_vsync_wrap();
      int fs_n = 0, vs_n = 0, ls_n = 0, y_max = 0;
      int fs_first = -1, fs_last = -1;
      for (int p = 48; p < 144; p++) begin
         tick();
         if (frame_start) begin
            fs_n++;
            if (fs_first < 0) fs_first = p;
            fs_last = p;
         end
         if (!lcd_vsync) vs_n++;
         if (line_start) ls_n++;
         if (int'(y) > y_max) y_max = int'(y);
         n_cmp++;
         if (got !== exp_at(p)) begin
            n_fail++;
            $display("FAIL vsync_wrap p%0d: got %b want %b", p, got, exp_at(p));
         end
      end
      n_cmp++;
      if (fs_n !== 2) begin
         n_fail++;
         $display("FAIL frame_start_count: got %0d want 2", fs_n);
      end
      n_cmp++;
      if (fs_last - fs_first !== 48) begin
         n_fail++;
         $display("FAIL frame_period: got %0d want 48", fs_last - fs_first);
      end
      n_cmp++;
      if (vs_n !== 16) begin
         n_fail++;
         $display("FAIL vsync_low_count: got %0d want 16", vs_n);
      end
      n_cmp++;
      if (ls_n !== 6) begin
         n_fail++;
         $display("FAIL line_start_count: got %0d want 6", ls_n);
      end
      n_cmp++;
      if (y_max !== 2) begin
         n_fail++;
         $display("FAIL y_max: got %0d want 2", y_max);
      end
   endtask

   task automatic test_mid_reset();
      // after observing p=153 the counters sit at line 1, pixel 2
      for (int p = 144; p < 154; p++) begin
         tick();
         n_cmp++;
         if (got !== exp_at(p)) begin
            n_fail++;
            $display("FAIL pre_reset p%0d: got %b want %b", p, got, exp_at(p));
         end
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (got !== IDLE) begin
         n_fail++;
         $display("FAIL mid_reset_idle: got %b want %b", got, IDLE);
      end
      rst = 1'b0;
      for (int p = 0; p < 10; p++) begin
         tick();
         n_cmp++;
         if (got !== exp_at(p)) begin
            n_fail++;
            $display("FAIL post_reset p%0d: got %b want %b", p, got, exp_at(p));
         end
      end
   endtask

   task automatic test_enable();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++;
         if (got !== IDLE) begin
            n_fail++;
            $display("FAIL en_low_idle clk%0d: got %b want %b", i, got, IDLE);
         end
      end
      en = 1'b1;
      for (int p = 0; p < 6; p++) begin
         tick();
         n_cmp++;
         if (got !== exp_at(p)) begin
            n_fail++;
            $display("FAIL en_resume p%0d: got %b want %b", p, got, exp_at(p));
         end
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (got !== IDLE) begin
            n_fail++;
            $display("FAIL rst_over_en clk%0d: got %b want %b", i, got, IDLE);
         end
      end
      rst = 1'b0;
      for (int p = 0; p < 4; p++) begin
         tick();
         n_cmp++;
         if (got !== exp_at(p)) begin
            n_fail++;
            $display("FAIL rst_release p%0d: got %b want %b", p, got, exp_at(p));
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_hsync();
      test_vsync_wrap();
      test_mid_reset();
      test_enable();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
